// File: rtl/serial_full_adder.sv
// rtl/serial_full_adder.sv - bit-serial A+B+Cin adder, LSB first, one full-adder cell
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_next;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

    assign s        = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    // New bit enters at the MSB; after WIDTH shifts bit 0 holds the first sum bit.
    assign res_cat  = {s, res};
    assign res_next = res_cat[WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res   <= res_next;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= c_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
- Bit-serial adder: the addition counterpart of the lab's full subtractor.
- Computes A + B + Cin over WIDTH bits, LSB first, one bit per clock.
- Uses a single full-adder cell and a registered carry.
- Start/busy/done handshake; result is presented in parallel once the operation completes.
- Serves as the arithmetic building block for sequential datapath labs.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry in; sampled on the accepting edge
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset:
  - State goes to IDLE immediately on rst_n low.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, latch a, b into operand shift registers and cin into the carry flop.
  - Clear the counter and go to SHIFT.
  - busy rises after this edge (edge 0).
- SHIFT, edges 1..WIDTH (one bit per edge):
  - s = a_sr[0] ^ b_sr[0] ^ c.
  - c_next = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0])).
  - s is shifted into the MSB of the internal result register.
  - a_sr and b_sr shift right; counter increments.
  - On the edge where counter reaches WIDTH-1: copy the completed result into sum, load c_next into cout, go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge returns to IDLE with done=0, busy=0.
- Latency: done is high in the cycle following edge WIDTH, counting the accepting edge as edge 0.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is accepted on the edge leaving DONE+1, i.e. the first edge in IDLE.
- Output stability:
  - sum and cout never show intermediate values.
  - They change only on the edge entering DONE.
  - They hold until the next completion or reset.
- start while busy (SHIFT or DONE) is ignored. No queuing, no effect on the operation in progress.
- a, b, cin may change freely after the accepting edge without affecting the result.
- WIDTH=1: SHIFT lasts one edge; the block behaves as a registered full adder.
- Overflow: the result is modulo 2^WIDTH, with the carry reported in cout. cin=1 with a=b=all-ones gives sum=all-ones, cout=1.
- Reset mid-operation:
  - Aborts immediately; outputs cleared, no done pulse.
  - The first start after rst_n deasserts is accepted normally.
- start held high continuously: a new operation begins on every IDLE edge, giving back-to-back operations of WIDTH+2 cycles each.

Test Plan:
- WIDTH=1, all 8 (a,b,cin) combinations 000..111 → {cout,sum} = 00,01,01,10,01,10,10,11. done exactly 2 edges after acceptance each time.
- WIDTH=8: a=0x37, b=0x29, cin=0 → sum=0x60, cout=0. done one cycle after edge 8; busy high 9 cycles.
- WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x5A, b=0xA5, cin=1 → sum=0x00, cout=1. Then a=b=0xFF, cin=1 → sum=0xFF, cout=1.
- WIDTH=8: start with a=0x10, b=0x20; pulse start again at edge 3 with a=0xFF, b=0xFF. Change a, b mid-operation → result 0x30, cout=0; second start ignored; exactly one done pulse.
- WIDTH=8: start a=0x80, b=0x80; assert rst_n low at edge 4 → busy, done, sum, cout go to 0 asynchronously with no done pulse. After release, a=0x01, b=0x02 → sum=0x03.
- start held high for 3 operations → done pulses spaced exactly WIDTH+2 cycles apart; sum stays stable between pulses.
